boundary_scan_register: RTL and testbench
=========================================

BOUNDARY_SCAN_REGISTER -- requirements
Module: boundary_scan_register

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, number of input-pad boundary cells (>=1).
REQ-002 SHALL have parameter NUM_OUT, default 4, number of output-pad boundary cells (>=1).
REQ-003 SHALL have port tck  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port trst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port bsr_tdi  input  1  serial scan data in from the TAP data-register path.
REQ-006 SHALL have port bsr_clk  input  1  scan enable, sampled on tck; high = capture or shift this cycle.
REQ-007 SHALL have port bsr_capture  input  1  qualifies bsr_clk: high = capture, low = shift.
REQ-008 SHALL have port bsr_update  input  1  update-stage load strobe, sampled on tck.
REQ-009 SHALL have port extest  input  1  high = pad_out driven from output-cell update stage.
REQ-010 SHALL have port intest  input  1  high = core_in driven from input-cell update stage.
REQ-011 SHALL have port pad_in  input  NUM_IN  values from input pads.
REQ-012 SHALL have port core_out  input  NUM_OUT  functional values from core logic.
REQ-013 SHALL have port core_in  output  NUM_IN  values presented to core.
REQ-014 SHALL have port pad_out  output  NUM_OUT  values presented to output pads.
REQ-015 SHALL have port bsr_tdo  output  1  serial scan data out to the TAP data-register mux.

Function
REQ-016 SHALL hold a shift stage sh[T-1:0], T = NUM_IN+NUM_OUT; cells 0..NUM_IN-1 input cells, NUM_IN..T-1 output cells.
REQ-017 SHALL hold an update stage up[T-1:0], same cell mapping, loaded only from sh.
REQ-018 SHALL drive bsr_tdo = sh[0] directly from the flop, no combinational path from bsr_tdi.
REQ-019 SHALL, when bsr_clk=1 and bsr_capture=1, load sh[NUM_IN-1:0] <= pad_in and sh[T-1:NUM_IN] <= core_out in one cycle.
REQ-020 SHALL, when bsr_clk=1 and bsr_capture=0, shift one bit per cycle: sh <= {bsr_tdi, sh[T-1:1]}.
REQ-021 SHALL hold sh unchanged when bsr_clk=0.
REQ-022 SHALL, when bsr_update=1, load up <= sh using the pre-edge sh value, regardless of bsr_clk in the same cycle.
REQ-023 SHALL hold up unchanged when bsr_update=0; up is not affected by capture or shift.
REQ-024 SHALL drive pad_out = extest ? up[T-1:NUM_IN] : core_out, combinational on mode input.
REQ-025 SHALL drive core_in = intest ? up[NUM_IN-1:0] : pad_in, combinational on mode input.
REQ-026 SHALL treat extest and intest independently; both high applies both muxes.
REQ-027 SHALL make serial order: after T shift cycles of stream b0,b1,...,b(T-1), sh[i] = b(i); first bit out on bsr_tdo is sh[0].
REQ-028 SHALL have no latency beyond one tck for capture, shift, update; mode muxes zero-cycle.

Reset
REQ-029 SHALL, on tck edge with trst=1, clear sh and up to all zeros; trst overrides capture, shift, update that cycle.
REQ-030 SHALL give post-reset outputs: bsr_tdo=0; pad_out=core_out and core_in=pad_in unless extest/intest high (then zeros).
REQ-031 SHALL allow reset mid-shift; partial shift contents discarded, next shift starts from all-zero sh.

Verification (NUM_IN=4, NUM_OUT=4)
REQ-032 SHALL cover reset: trst=1 one cycle, extest=intest=0, core_out=4'h9, pad_in=4'h6 -> bsr_tdo=0, pad_out=4'h9, core_in=4'h6.
REQ-033 SHALL cover capture+shift: pad_in=4'hA, core_out=4'h5, one capture cycle, 8 shift cycles bsr_tdi=0 -> bsr_tdo sequence 0,1,0,1,1,0,1,0 then 0.
REQ-034 SHALL cover preload+extest/intest: shift 8'hC3 LSB first, bsr_update one cycle, extest=intest=1 -> pad_out=4'hC, core_in=4'h3; deassert modes -> pad_out=core_out, core_in=pad_in.
REQ-035 SHALL cover simultaneous update and shift: sh=8'hC3, bsr_clk=1, bsr_capture=0, bsr_update=1, bsr_tdi=1 same cycle -> up=8'hC3, sh=8'hE1.
REQ-036 SHALL cover idle hold: bsr_clk=0 for 5 cycles with toggling bsr_tdi -> sh and bsr_tdo unchanged.
REQ-037 SHALL cover reset mid-shift: 3 shifts of 1, trst=1, then 8 shifts of 0 -> bsr_tdo all 0, up unchanged at 0.

Source files
------------

// File: rtl/boundary_scan_register.sv
// boundary_scan_register: JTAG boundary-scan chain (shift/capture stage sh, update stage up, EXTEST/INTEST pad muxes); tck/trst clock+sync reset, bsr_* scan controls, pad_in/core_out sampled, core_in/pad_out/bsr_tdo driven
module boundary_scan_register #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 4
) (
  input  logic               tck,
  input  logic               trst,
  input  logic               bsr_tdi,
  input  logic               bsr_clk,
  input  logic               bsr_capture,
  input  logic               bsr_update,
  input  logic               extest,
  input  logic               intest,
  input  logic [NUM_IN-1:0]  pad_in,
  input  logic [NUM_OUT-1:0] core_out,
  output logic [NUM_IN-1:0]  core_in,
  output logic [NUM_OUT-1:0] pad_out,
  output logic               bsr_tdo
);
  localparam int T = NUM_IN + NUM_OUT;
  logic [T-1:0] sh, up;
  always_ff @(posedge tck)
    if (trst) begin
      sh <= '0;
      up <= '0;
    end else begin
      if (bsr_clk) sh <= bsr_capture ? {core_out, pad_in} : {bsr_tdi, sh[T-1:1]};
      if (bsr_update) up <= sh;
    end
  assign bsr_tdo = sh[0];
  assign pad_out = extest ? up[T-1:NUM_IN] : core_out;
  assign core_in = intest ? up[NUM_IN-1:0] : pad_in;
endmodule

// File: tb/tb_boundary_scan_register.sv
// tb_boundary_scan_register: self-checking bench with a queue-based reference model of the scan chain
module tb_boundary_scan_register;
  localparam int NI = 4, NO = 4, T = NI + NO;
  logic tck = 0, trst = 0, bsr_tdi = 0, bsr_clk = 0, bsr_capture = 0, bsr_update = 0;
  logic extest = 0, intest = 0, bsr_tdo;
  logic [NI-1:0] pad_in = '0, core_in;
  logic [NO-1:0] core_out = '0, pad_out;
  int checks = 0, failures = 0;
  bit ms[$];
  bit mu[$];

  boundary_scan_register #(.NUM_IN(NI), .NUM_OUT(NO)) dut (
    .tck(tck), .trst(trst), .bsr_tdi(bsr_tdi), .bsr_clk(bsr_clk),
    .bsr_capture(bsr_capture), .bsr_update(bsr_update), .extest(extest),
    .intest(intest), .pad_in(pad_in), .core_out(core_out), .core_in(core_in),
    .pad_out(pad_out), .bsr_tdo(bsr_tdo)
  );

  always #5 tck = ~tck;

  function automatic logic [NO-1:0] exp_po();
    logic [NO-1:0] v;
    for (int i = 0; i < NO; i++) v[i] = extest ? mu[NI+i] : core_out[i];
    return v;
  endfunction

  function automatic logic [NI-1:0] exp_ci();
    logic [NI-1:0] v;
    for (int i = 0; i < NI; i++) v[i] = intest ? mu[i] : pad_in[i];
    return v;
  endfunction

  task automatic cyc(input logic c, input logic cap, input logic d, input logic u, input logic r);
    bit nq[$];
    bsr_clk = c; bsr_capture = cap; bsr_tdi = d; bsr_update = u; trst = r;
    @(posedge tck);
    if (r) begin
      ms = {}; mu = {};
      for (int i = 0; i < T; i++) begin ms.push_back(0); mu.push_back(0); end
    end else begin
      if (u) mu = ms;
      if (c && cap) begin
        for (int i = 0; i < NI; i++) nq.push_back(pad_in[i]);
        for (int i = 0; i < NO; i++) nq.push_back(core_out[i]);
        ms = nq;
      end else if (c) begin
        void'(ms.pop_front());
        ms.push_back(d);
      end
    end
    #1;
    bsr_clk = 0; bsr_update = 0; trst = 0;
  endtask

  task automatic test_reset;
    extest = 0; intest = 0; core_out = 4'h9; pad_in = 4'h6;
    cyc(1, 1, 1, 1, 1);
    checks++; if (bsr_tdo !== 1'b0) begin failures++; $display("FAIL reset_tdo got=%b exp=0", bsr_tdo); end
    checks++; if (pad_out !== 4'h9) begin failures++; $display("FAIL reset_pad_out got=%h exp=9", pad_out); end
    checks++; if (core_in !== 4'h6) begin failures++; $display("FAIL reset_core_in got=%h exp=6", core_in); end
    extest = 1; intest = 1; #1;
    checks++; if (pad_out !== 4'h0) begin failures++; $display("FAIL reset_pad_out_ext got=%h exp=0", pad_out); end
    checks++; if (core_in !== 4'h0) begin failures++; $display("FAIL reset_core_in_int got=%h exp=0", core_in); end
    extest = 0; intest = 0;
  endtask

  task automatic test_capture_shift;
    logic [8:0] seq = 9'b0_0101_1010;
    pad_in = 4'hA; core_out = 4'h5;
    cyc(1, 1, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (bsr_tdo !== seq[k]) begin failures++; $display("FAIL capture_shift_tdo[%0d] got=%b exp=%b", k, bsr_tdo, seq[k]); end
      if (k < 8) cyc(1, 0, 0, 0, 0);
    end
  endtask

  task automatic test_preload;
    logic [7:0] pat = 8'hC3;
    for (int k = 0; k < 8; k++) cyc(1, 0, pat[k], 0, 0);
    cyc(0, 0, 0, 1, 0);
    core_out = 4'h7; pad_in = 4'h8; extest = 1; intest = 1; #1;
    checks++; if (pad_out !== 4'hC) begin failures++; $display("FAIL preload_pad_out got=%h exp=C", pad_out); end
    checks++; if (core_in !== 4'h3) begin failures++; $display("FAIL preload_core_in got=%h exp=3", core_in); end
    extest = 0; intest = 0; #1;
    checks++; if (pad_out !== 4'h7) begin failures++; $display("FAIL preload_off_pad_out got=%h exp=7", pad_out); end
    checks++; if (core_in !== 4'h8) begin failures++; $display("FAIL preload_off_core_in got=%h exp=8", core_in); end
  endtask

  task automatic test_update_shift;
    logic [7:0] e = 8'hE1;
    cyc(1, 0, 1, 1, 0);
    extest = 1; intest = 1; #1;
    checks++; if ({pad_out, core_in} !== 8'hC3) begin failures++; $display("FAIL upd_shift_up got=%h exp=C3", {pad_out, core_in}); end
    extest = 0; intest = 0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bsr_tdo !== e[k]) begin failures++; $display("FAIL upd_shift_sh[%0d] got=%b exp=%b", k, bsr_tdo, e[k]); end
      cyc(1, 0, 0, 0, 0);
    end
  endtask

  task automatic test_idle;
    logic saved;
    for (int k = 0; k < 8; k++) cyc(1, 0, k[0] ^ k[2], 0, 0);
    saved = bsr_tdo;
    for (int k = 0; k < 5; k++) begin
      cyc(0, k[0], ~k[0], 0, 0);
      checks++;
      if (bsr_tdo !== saved || bsr_tdo !== ms[0]) begin failures++; $display("FAIL idle_tdo[%0d] got=%b exp=%b", k, bsr_tdo, saved); end
    end
  endtask

  task automatic test_reset_mid_shift;
    repeat (3) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 1);
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 0, 0, 0);
      checks++;
      if (bsr_tdo !== 1'b0) begin failures++; $display("FAIL mid_reset_tdo[%0d] got=%b exp=0", k, bsr_tdo); end
    end
    extest = 1; intest = 1; #1;
    checks++; if ({pad_out, core_in} !== 8'h00) begin failures++; $display("FAIL mid_reset_up got=%h exp=00", {pad_out, core_in}); end
    extest = 0; intest = 0;
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      pad_in = NI'($urandom); core_out = NO'($urandom);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 1'($urandom),
          $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
      extest = 1'($urandom); intest = 1'($urandom);
      pad_in = NI'($urandom); core_out = NO'($urandom); #1;
      checks++;
      if (bsr_tdo !== ms[0] || pad_out !== exp_po() || core_in !== exp_ci()) begin
        failures++;
        $display("FAIL random[%0d] got tdo=%b po=%h ci=%h exp tdo=%b po=%h ci=%h",
                 n, bsr_tdo, pad_out, core_in, ms[0], exp_po(), exp_ci());
      end
    end
  endtask

  initial begin
    #2;
    test_reset;
    test_capture_shift;
    test_preload;
    test_update_shift;
    test_idle;
    test_reset_mid_shift;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
